elevator_call_panel: RTL

ELEVATOR_CALL_PANEL -- requirements
Module: elevator_call_panel

---
 rtl/elevator_pkg.sv | 28 ++
 rtl/elevator_call_panel_if.sv | 35 +++
 rtl/button_debounce.sv | 40 ++++
 rtl/elevator_call_panel.sv | 96 +++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared request bit layout, floor service masks and helpers for the elevator call panel.
package elevator_pkg;

  localparam int unsigned NUM_REQ = 7;

  localparam int unsigned REQ_F1_UP   = 0;
  localparam int unsigned REQ_F2_UP   = 1;
  localparam int unsigned REQ_F2_DOWN = 2;
  localparam int unsigned REQ_F3_DOWN = 3;
  localparam int unsigned REQ_CAR_F1  = 4;
  localparam int unsigned REQ_CAR_F2  = 5;
  localparam int unsigned REQ_CAR_F3  = 6;

  localparam logic [NUM_REQ-1:0] MASK_F1 = NUM_REQ'((1 << REQ_F1_UP) | (1 << REQ_CAR_F1));
  localparam logic [NUM_REQ-1:0] MASK_F2 =
      NUM_REQ'((1 << REQ_F2_UP) | (1 << REQ_F2_DOWN) | (1 << REQ_CAR_F2));
  localparam logic [NUM_REQ-1:0] MASK_F3 = NUM_REQ'((1 << REQ_F3_DOWN) | (1 << REQ_CAR_F3));

  function automatic logic [2:0] count_ones(input logic [NUM_REQ-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/elevator_call_panel_if.sv
// Button, position and request signals between the call panel and its environment.
interface elevator_call_panel_if;
  import elevator_pkg::*;

  logic               btn_f1_up;
  logic               btn_f2_up;
  logic               btn_f2_down;
  logic               btn_f3_down;
  logic               btn_car_f1;
  logic               btn_car_f2;
  logic               btn_car_f3;
  logic               floor_one;
  logic               floor_two;
  logic               floor_three;
  logic               elevator_open;
  logic [NUM_REQ-1:0] req;
  logic               any_pending;
  logic [2:0]         pending_count;
  logic               door_alarm;

  modport master (
    output btn_f1_up, btn_f2_up, btn_f2_down, btn_f3_down,
    output btn_car_f1, btn_car_f2, btn_car_f3,
    output floor_one, floor_two, floor_three, elevator_open,
    input  req, any_pending, pending_count, door_alarm
  );

  modport slave (
    input  btn_f1_up, btn_f2_up, btn_f2_down, btn_f3_down,
    input  btn_car_f1, btn_car_f2, btn_car_f3,
    input  floor_one, floor_two, floor_three, elevator_open,
    output req, any_pending, pending_count, door_alarm
  );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stable-high counter; qualifies after DEBOUNCE_CYCLES high samples.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_qualified
);

  // The counter saturates one short of the target; the current sample supplies the last one.
  localparam logic [3:0] CntSat = 4'(DEBOUNCE_CYCLES - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_d;

  always_comb begin
    w_cnt_d = 4'd0;
    if (r_sync2) begin
      w_cnt_d = (r_cnt >= CntSat) ? CntSat : r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_d;
    end
  end

  assign o_qualified = r_sync2 && (r_cnt >= CntSat);

endmodule

// File: rtl/elevator_call_panel.sv
// Latched hall/car call requests with floor service clearing and a door-open alarm timer.
// Optional per-button debounce is compiled in with ELEVATOR_CALL_DEBOUNCE_EN.
module elevator_call_panel
  import elevator_pkg::*;
#(
    parameter int unsigned DOOR_TIMEOUT    = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    elevator_call_panel_if.slave io_panel
);

  if (DOOR_TIMEOUT < 2 || DOOR_TIMEOUT > 255) begin : g_bad_timeout
    $error("DOOR_TIMEOUT out of range 2..255");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 1..15");
  end

  logic [NUM_REQ-1:0] w_raw;
  logic [NUM_REQ-1:0] w_btn_q;
  logic [NUM_REQ-1:0] w_clr;
  logic [NUM_REQ-1:0] w_req_d;
  logic               w_svc_f1;
  logic               w_svc_f2;
  logic               w_svc_f3;
  logic [7:0]         w_door_cnt_d;

  logic [NUM_REQ-1:0] r_req;
  logic               r_any_pending;
  logic [2:0]         r_pending_count;
  logic [7:0]         r_door_cnt;

  assign w_raw = {io_panel.btn_car_f3, io_panel.btn_car_f2, io_panel.btn_car_f1,
                  io_panel.btn_f3_down, io_panel.btn_f2_down, io_panel.btn_f2_up,
                  io_panel.btn_f1_up};

`ifdef ELEVATOR_CALL_DEBOUNCE_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_db
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk        (clk),
      .rst        (rst),
      .i_btn      (w_raw[gi]),
      .o_qualified(w_btn_q[gi])
    );
  end
`else
  assign w_btn_q = w_raw;
`endif

  always_comb begin
    // Service only when exactly one floor indicator is high.
    w_svc_f1 = io_panel.elevator_open && io_panel.floor_one &&
               !io_panel.floor_two && !io_panel.floor_three;
    w_svc_f2 = io_panel.elevator_open && !io_panel.floor_one &&
               io_panel.floor_two && !io_panel.floor_three;
    w_svc_f3 = io_panel.elevator_open && !io_panel.floor_one &&
               !io_panel.floor_two && io_panel.floor_three;
    w_clr = '0;
    if (w_svc_f1) w_clr = w_clr | MASK_F1;
    if (w_svc_f2) w_clr = w_clr | MASK_F2;
    if (w_svc_f3) w_clr = w_clr | MASK_F3;
    // Clear dominates set, so a press at the servicing edge is dropped.
    w_req_d = (r_req | w_btn_q) & ~w_clr;
  end

  always_comb begin
    w_door_cnt_d = 8'd0;
    if (io_panel.elevator_open) begin
      w_door_cnt_d = (r_door_cnt == 8'(DOOR_TIMEOUT)) ? r_door_cnt : r_door_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req           <= '0;
      r_any_pending   <= 1'b0;
      r_pending_count <= 3'd0;
      r_door_cnt      <= 8'd0;
    end else begin
      r_req           <= w_req_d;
      r_any_pending   <= |w_req_d;
      r_pending_count <= count_ones(w_req_d);
      r_door_cnt      <= w_door_cnt_d;
    end
  end

  assign io_panel.req           = r_req;
  assign io_panel.any_pending   = r_any_pending;
  assign io_panel.pending_count = r_pending_count;
  assign io_panel.door_alarm    = (r_door_cnt == 8'(DOOR_TIMEOUT));

endmodule
